// File: rtl/split_stream_pkt_fifo.sv
// split_stream_pkt_fifo: broadcasts each stream packet into per-output FIFOs, blocking or dropping on full.
// Define SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN to add per-output saturating drop counters.
module split_stream_pkt_fifo #(
    parameter int WIDTH = 16,
    parameter int NUM_OUTPUTS = 4,
    parameter logic [NUM_OUTPUTS-1:0] ACTIVE_MASK = '1,
    parameter int FIFOSIZE = 6,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [NUM_OUTPUTS-1:0]       en_mask,
    input  logic [WIDTH-1:0]             i_tdata,
    input  logic                         i_tlast,
    input  logic                         i_tvalid,
    output logic                         i_tready,
    output logic [NUM_OUTPUTS*WIDTH-1:0] o_tdata,
    output logic [NUM_OUTPUTS-1:0]       o_tlast,
    output logic [NUM_OUTPUTS-1:0]       o_tvalid,
    input  logic [NUM_OUTPUTS-1:0]       o_tready
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
    ,
    output logic [NUM_OUTPUTS*16-1:0]    drop_count
`endif
);
    localparam logic [FIFOSIZE:0] DEPTH = {1'b1, {FIFOSIZE{1'b0}}};

    logic flush, sop, accept;
    logic [NUM_OUTPUTS-1:0] held, enabled, full;

    assign flush = reset | clear;
    // the enable set is latched on the first beat and frozen for the rest of the packet
    assign enabled = sop ? (ACTIVE_MASK & en_mask) : held;
    assign i_tready = !flush && (DROP_ON_FULL || !(|(enabled & full)));
    assign accept = i_tvalid & i_tready;

    always_ff @(posedge clk) begin
        if (flush) begin
            sop <= 1'b1;
            held <= '0;
        end else if (accept) begin
            sop <= i_tlast;
            held <= enabled;
        end
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
        if (ACTIVE_MASK[k]) begin : g_on
            logic [WIDTH:0] mem [2**FIFOSIZE];
            logic [FIFOSIZE:0] wp, cp, rp;
            logic dropping, hit, write, drop_end, set_drop, pop;

            assign full[k] = (wp - rp) == DEPTH;
            assign hit = accept & enabled[k];
            assign write = hit & !dropping & !full[k];
            assign drop_end = hit & i_tlast & (dropping | full[k]);
            assign set_drop = hit & !i_tlast & !dropping & full[k];
            // only committed entries are visible; blocking mode commits every beat
            assign o_tvalid[k] = !flush && (cp != rp);
            assign pop = o_tvalid[k] & o_tready[k];
            assign {o_tlast[k], o_tdata[k*WIDTH +: WIDTH]} = o_tvalid[k] ? mem[rp[FIFOSIZE-1:0]] : '0;

            always_ff @(posedge clk) begin
                if (write)
                    mem[wp[FIFOSIZE-1:0]] <= {i_tlast, i_tdata};
            end

            always_ff @(posedge clk) begin
                if (flush) begin
                    wp <= '0;
                    cp <= '0;
                    rp <= '0;
                    dropping <= 1'b0;
                end else begin
                    if (pop)
                        rp <= rp + 1'b1;
                    if (write) begin
                        wp <= wp + 1'b1;
                        if (i_tlast || !DROP_ON_FULL)
                            cp <= wp + 1'b1;
                    end else if (drop_end) begin
                        wp <= cp;
                        dropping <= 1'b0;
                    end else if (set_drop) begin
                        dropping <= 1'b1;
                    end
                end
            end

`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
            logic [15:0] cnt;
            always_ff @(posedge clk) begin
                if (flush)
                    cnt <= '0;
                else if (drop_end && cnt != 16'hFFFF)
                    cnt <= cnt + 1'b1;
            end
            assign drop_count[k*16 +: 16] = cnt;
`else
`endif
        end else begin : g_off
            assign full[k] = 1'b0;
            assign o_tvalid[k] = 1'b0;
            assign o_tlast[k] = 1'b0;
            assign o_tdata[k*WIDTH +: WIDTH] = '0;
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
            assign drop_count[k*16 +: 16] = '0;
`endif
        end
    end
endmodule

// File: tb/tb_split_stream_pkt_fifo.sv
// tb_split_stream_pkt_fifo: blocking and dropping instances checked every cycle against a queue-based packet model.
module tb_split_stream_pkt_fifo;
    localparam int DEPTH = 4;
    localparam logic [1:0][3:0] ACT = {4'h7, 4'hF};

    logic clk = 1'b0, reset = 1'b1, rnd = 1'b0;
    logic [1:0] clear = '0, tv = '0, tl = '0;
    logic [1:0][3:0] en = '1, ordy = '1;
    logic [1:0][15:0] td = '0;
    wire [1:0] tr;
    wire [1:0][3:0] ov, ol;
    wire [1:0][63:0] od;
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
    wire [1:0][63:0] dc;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    split_stream_pkt_fifo #(.WIDTH(16), .NUM_OUTPUTS(4), .ACTIVE_MASK(4'hF), .FIFOSIZE(2), .DROP_ON_FULL(1'b0)) u_blk (
        .clk(clk), .reset(reset), .clear(clear[0]), .en_mask(en[0]),
        .i_tdata(td[0]), .i_tlast(tl[0]), .i_tvalid(tv[0]), .i_tready(tr[0]),
        .o_tdata(od[0]), .o_tlast(ol[0]), .o_tvalid(ov[0]), .o_tready(ordy[0])
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
        , .drop_count(dc[0])
`endif
    );

    split_stream_pkt_fifo #(.WIDTH(16), .NUM_OUTPUTS(4), .ACTIVE_MASK(4'h7), .FIFOSIZE(2), .DROP_ON_FULL(1'b1)) u_drp (
        .clk(clk), .reset(reset), .clear(clear[1]), .en_mask(en[1]),
        .i_tdata(td[1]), .i_tlast(tl[1]), .i_tvalid(tv[1]), .i_tready(tr[1]),
        .o_tdata(od[1]), .o_tlast(ol[1]), .o_tvalid(ov[1]), .o_tready(ordy[1])
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
        , .drop_count(dc[1])
`endif
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // reference: per output a queue of committed beats and a queue of the packet still arriving
    logic [16:0] cq [2][4][$];
    logic [16:0] pq [2][4][$];
    bit dropping [2][4];
    bit sop [2];
    logic [3:0] held [2];
    int dcnt [2][4];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin : cmp
            logic [3:0] xv, xl, enab, full;
            logic [63:0] xd, xdc;
            logic xr, fl;
            fl = reset || clear[d];
            xv = '0; xl = '0; xd = '0; xdc = '0; full = '0;
            enab = sop[d] ? (en[d] & ACT[d]) : held[d];
            for (int k = 0; k < 4; k++) begin
                full[k] = (cq[d][k].size() + pq[d][k].size()) >= DEPTH;
                xdc[k*16 +: 16] = 16'(dcnt[d][k]);
                if (!fl && cq[d][k].size() > 0) begin
                    xv[k] = 1'b1;
                    xl[k] = cq[d][k][0][16];
                    xd[k*16 +: 16] = cq[d][k][0][15:0];
                end
            end
            xr = !fl && (d == 1 || (enab & full) == 4'h0);
            chk($sformatf("dut%0d i_tready", d), 64'(tr[d]), 64'(xr));
            chk($sformatf("dut%0d o_tvalid", d), 64'(ov[d]), 64'(xv));
            chk($sformatf("dut%0d o_tlast", d), 64'(ol[d]), 64'(xl));
            chk($sformatf("dut%0d o_tdata", d), od[d], xd);
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
            chk($sformatf("dut%0d drop_count", d), dc[d], xdc);
`endif
            if (fl) begin
                for (int k = 0; k < 4; k++) begin
                    cq[d][k].delete();
                    pq[d][k].delete();
                    dropping[d][k] = 1'b0;
                    dcnt[d][k] = 0;
                end
                sop[d] = 1'b1;
                held[d] = '0;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (xv[k] && ordy[d][k]) void'(cq[d][k].pop_front());
                if (tv[d] && xr) begin
                    if (sop[d]) held[d] = enab;
                    for (int k = 0; k < 4; k++) begin
                        if (!enab[k]) continue;
                        if (d == 0) cq[d][k].push_back({tl[d], td[d]});
                        else if (tl[d]) begin
                            if (dropping[d][k] || full[k]) begin
                                pq[d][k].delete();
                                dropping[d][k] = 1'b0;
                                if (dcnt[d][k] < 65535) dcnt[d][k]++;
                            end else begin
                                pq[d][k].push_back({tl[d], td[d]});
                                while (pq[d][k].size() > 0) cq[d][k].push_back(pq[d][k].pop_front());
                            end
                        end else if (!dropping[d][k]) begin
                            if (full[k]) dropping[d][k] = 1'b1;
                            else pq[d][k].push_back({tl[d], td[d]});
                        end
                    end
                    sop[d] = tl[d];
                end
            end
        end
    end

    task automatic step(input int d);
        @(posedge clk);
        #1;
        if (rnd) ordy[d] = 4'($urandom);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) step(d);
    endtask

    task automatic send(input int d, input logic [15:0] data, input logic last);
        int n = 0;
        tv[d] = 1'b1; td[d] = data; tl[d] = last;
        forever begin
            @(negedge clk);
            if (tr[d]) break;
            if (++n > 200) begin
                checks++; errors++;
                $display("FAIL dut%0d send timeout: waited %0d cycles, limit 200", d, n);
                tv[d] = 1'b0;
                return;
            end
            step(d);
        end
        step(d);
        tv[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset i_tready", 64'(tr), 64'h0);
        chk("reset o_tvalid", 64'({ov[1], ov[0]}), 64'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // full-speed broadcast, first beat visible one cycle after acceptance
        send(0, 16'd1, 1'b0);
        @(negedge clk);
        chk("first beat o_tvalid", 64'(ov[0]), 64'hF);
        chk("first beat o_tdata0", 64'(od[0][15:0]), 64'd1);
        for (int i = 2; i <= 8; i++) send(0, 16'(i), i == 8);
        idle(0, 3);

        // blocked output stalls the input after its FIFO fills
        ordy[0] = 4'b1011;
        for (int i = 1; i <= 4; i++) send(0, 16'(16'h10 + i), 1'b0);
        tv[0] = 1'b1; td[0] = 16'h15; tl[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("blocking stall i_tready", 64'(tr[0]), 64'h0);
            step(0);
        end
        ordy[0] = 4'hF;
        send(0, 16'h15, 1'b0);
        send(0, 16'h16, 1'b1);
        idle(0, 4);
        @(negedge clk);
        chk("blocking drained", 64'(ov[0]), 64'h0);

        // enable change mid-packet takes effect on the next packet
        send(0, 16'h20, 1'b0);
        en[0] = 4'b0001;
        send(0, 16'h21, 1'b0);
        send(0, 16'h22, 1'b1);
        send(0, 16'h30, 1'b0);
        @(negedge clk);
        chk("en change next packet", 64'(ov[0]), 64'h1);
        send(0, 16'h31, 1'b1);
        idle(0, 3);
        en[0] = 4'hF;

        // clear mid-packet flushes everything
        ordy[0] = 4'h0;
        send(0, 16'h40, 1'b0);
        send(0, 16'h41, 1'b0);
        tv[0] = 1'b1; td[0] = 16'h42; clear[0] = 1'b1;
        step(0);
        clear[0] = 1'b0; tv[0] = 1'b0;
        @(negedge clk);
        chk("clear o_tvalid", 64'(ov[0]), 64'h0);
        ordy[0] = 4'hF;
        for (int i = 0; i < 3; i++) send(0, 16'(16'h50 + i), i == 2);
        idle(0, 3);

        // drop mode: stalled output keeps packet A, loses packet B
        ordy[1] = 4'b1101;
        for (int i = 1; i <= 3; i++) send(1, 16'(16'hA0 + i), i == 3);
        for (int i = 1; i <= 3; i++) send(1, 16'(16'hB0 + i), i == 3);
        idle(1, 3);
        @(negedge clk);
        chk("drop stalled o_tvalid", 64'(ov[1]), 64'h2);
        chk("drop stalled head", 64'(od[1][31:16]), 64'hA1);
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
        chk("drop_count out1", 64'(dc[1][31:16]), 64'd1);
`endif
        ordy[1] = 4'hF;
        idle(1, 5);

        // oversize packet dropped everywhere, next packet delivered
        for (int i = 1; i <= 5; i++) send(1, 16'(16'hC0 + i), i == 5);
        idle(1, 2);
        @(negedge clk);
        chk("oversize o_tvalid", 64'(ov[1]), 64'h0);
`ifdef SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN
        chk("oversize drop_count", dc[1], 64'h0000_0001_0002_0001);
`endif
        send(1, 16'hD1, 1'b1);
        @(negedge clk);
        chk("after drop o_tvalid", 64'(ov[1]), 64'h7);
        chk("after drop o_tdata0", 64'(od[1][15:0]), 64'hD1);
        idle(1, 3);

        // randomized traffic against the model
        for (int d = 0; d < 2; d++) begin
            rnd = 1'b1;
            for (int p = 0; p < 60; p++) begin
                int len;
                len = $urandom_range(1, 6);
                en[d] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
                for (int b = 0; b < len; b++) begin
                    if ($urandom_range(0, 3) == 0) idle(d, 1);
                    if ($urandom_range(0, 5) == 0) en[d] = 4'($urandom);
                    send(d, 16'($urandom), b == len - 1);
                end
            end
            rnd = 1'b0;
            ordy[d] = 4'hF;
            idle(d, 12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/split_stream_pkt_fifo.md
SPLIT_STREAM_PKT_FIFO -- requirements
Module: split_stream_pkt_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per beat.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 4, range 1..16, output channel count.
REQ-003 SHALL have parameter ACTIVE_MASK, default all ones (NUM_OUTPUTS bits); bit k=0 removes output k's storage.
REQ-004 SHALL have parameter FIFOSIZE, default 6; per-output depth 2^FIFOSIZE beats.
REQ-005 SHALL have parameter DROP_ON_FULL, default 0; 0=blocking broadcast, 1=per-output packet drop.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port clear, input, 1, synchronous flush, same effect as reset.
REQ-009 SHALL have port en_mask, input, NUM_OUTPUTS, runtime output enables.
REQ-010 SHALL have ports i_tdata (WIDTH), i_tlast (1), i_tvalid (1) as inputs and i_tready (1) as output.
REQ-011 SHALL have outputs o_tdata (NUM_OUTPUTS*WIDTH), o_tlast (NUM_OUTPUTS) and o_tvalid (NUM_OUTPUTS), and input o_tready (NUM_OUTPUTS); channel k occupies slice k.

Function
REQ-012 SHALL treat output k as "enabled" for a packet when ACTIVE_MASK[k] and en_mask[k] are both 1, with en_mask sampled on the packet's first beat and held until the beat with tlast.
REQ-013 SHALL store each accepted beat ({tlast,tdata}) in every enabled output's FIFO in the same cycle; all 2^FIFOSIZE entries usable; pointers FIFOSIZE+1 bits wide, wrapping modulo 2^(FIFOSIZE+1).
REQ-014 SHALL present a beat written in cycle N on o_tvalid/o_tdata no earlier than cycle N+1; no combinational input-to-output path.
REQ-015 SHALL, when DROP_ON_FULL=0, drive i_tready=1 only if every enabled output has at least one free entry; full is evaluated before the same-cycle read, so a same-cycle read does not free the entry.
REQ-016 SHALL, when DROP_ON_FULL=0, make each beat readable (committed) in the cycle after its write.
REQ-017 SHALL, when DROP_ON_FULL=1, drive i_tready=1 at all times outside reset/clear.
REQ-018 SHALL, when DROP_ON_FULL=1, keep per output a write pointer, a commit pointer and a dropping flag; o_tvalid[k] is high iff the commit pointer differs from the read pointer.
REQ-019 SHALL, in drop mode, on a beat for enabled output k with FIFO full (write ptr minus read ptr = depth), set dropping[k] and write no further beats of that packet to k.
REQ-020 SHALL, in drop mode, on the tlast beat: if dropping[k], rewind write ptr to commit ptr and clear dropping[k]; else write the beat and set commit ptr to the new write ptr.
REQ-021 SHALL drop, in drop mode, every packet longer than 2^FIFOSIZE beats on every output.
REQ-022 SHALL consume and discard beats when no output is enabled (i_tready=1).
REQ-023 SHALL tie o_tvalid, o_tlast and o_tdata of outputs with ACTIVE_MASK[k]=0 to 0 and ignore their o_tready.
REQ-024 SHALL pop output k's head entry when o_tvalid[k] and o_tready[k] are both high; a simultaneous push and pop on a full FIFO in drop mode counts as full.

Reset
REQ-025 SHALL, on reset or clear, zero all pointers, clear dropping flags, re-arm first-beat detection, and drive o_tvalid=0, o_tlast=0, o_tdata=0 and i_tready=0 while asserted.
REQ-026 SHALL discard any partially received or stored packet when reset or clear is asserted mid-packet.

Configuration
REQ-027 SHALL, with SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN defined, add output drop_count (NUM_OUTPUTS*16 bits), one counter per output, incremented on the tlast of each packet dropped on that output, saturating at 0xFFFF, and zeroed by reset/clear.
REQ-028 SHALL, without SPLIT_STREAM_PKT_FIFO_DROP_CNT_EN, omit the drop_count port and its logic.

Verification
REQ-029 SHALL cover: blocking mode, NUM_OUTPUTS=4, en_mask=4'b1111, 8-beat packet 1..8, all o_tready=1 -> each output emits 1..8 with tlast on 8, first o_tvalid one cycle after first input beat.
REQ-030 SHALL cover: blocking mode, FIFOSIZE=2, o_tready[2]=0, 6 beats sent -> i_tready drops after 4th beat; raising o_tready[2] resumes flow, with no loss and no duplication on any output.
REQ-031 SHALL cover: drop mode, FIFOSIZE=2, o_tready[1]=0, two 3-beat packets -> output 1 holds packet A only (o_tvalid stays asserted), packet B is absent from output 1, the other outputs hold A and B, and drop_count[1]=1.
REQ-032 SHALL cover: en_mask changed from 4'b1111 to 4'b0001 mid-packet -> the current packet goes to all outputs and the next packet goes to output 0 only.
REQ-033 SHALL cover: clear pulsed on beat 3 of a 5-beat packet -> all o_tvalid=0 next cycle, and the following packet is delivered intact.
REQ-034 SHALL cover: drop mode, 5-beat packet with FIFOSIZE=2 -> dropped on all outputs, all pointers restored, and drop_count increments by one per enabled output.
